// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_pkg
// Description : Shared encodings for the register-file write-port arbiter
//               and its pending-register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

  // Owner encoding of a long-latency result.
  localparam logic SRC_MDU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  // Hard-wired zero register.
  localparam logic [4:0] REG_X0 = 5'd0;

  // Width of the starvation counter.
  localparam int STARVE_W = 4;

  // Which writer owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MDU  = 2'd2,
    GNT_LSU  = 2'd3
  } gnt_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter_if
// Description : Bundle of all writer, issue, query and register-file write
//               port signals around rf_wb_arbiter.
//   master : pipeline/MDU/LSU/decode side (drives requests, sees grants)
//   slave  : arbiter side (sees requests, drives grants/status/rf port)
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_wb_arbiter_if;
  logic        pipe_wen;
  logic [4:0]  pipe_wa;
  logic [31:0] pipe_wd;

  logic        mdu_valid;
  logic [4:0]  mdu_wa;
  logic [31:0] mdu_wd;
  logic        mdu_ready;

  logic        lsu_valid;
  logic [4:0]  lsu_wa;
  logic [31:0] lsu_wd;
  logic        lsu_ready;

  logic        iss_valid;
  logic        iss_src;
  logic [4:0]  iss_rd;

  logic [4:0]  qa;
  logic [4:0]  qb;
  logic        busy_a;
  logic        busy_b;

  logic        stall_req;
  logic        rf_wen;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        sb_err;

  modport master (
    output pipe_wen, pipe_wa, pipe_wd,
    output mdu_valid, mdu_wa, mdu_wd,
    input  mdu_ready,
    output lsu_valid, lsu_wa, lsu_wd,
    input  lsu_ready,
    output iss_valid, iss_src, iss_rd,
    output qa, qb,
    input  busy_a, busy_b,
    input  stall_req, rf_wen, rf_wa, rf_wd, sb_err
  );

  modport slave (
    input  pipe_wen, pipe_wa, pipe_wd,
    input  mdu_valid, mdu_wa, mdu_wd,
    output mdu_ready,
    input  lsu_valid, lsu_wa, lsu_wd,
    output lsu_ready,
    input  iss_valid, iss_src, iss_rd,
    input  qa, qb,
    output busy_a, busy_b,
    output stall_req, rf_wen, rf_wa, rf_wd, sb_err
  );
endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : rf_scoreboard
// Description : Pending-register scoreboard. Tracks destinations of issued
//               long-latency ops, which unit owns each, answers decode
//               busy queries and flags double issue (sticky sb_err).
// Ports       : clock, reset (async active-low)
//               iss_valid/iss_src/iss_rd : issue of a long-latency op
//               wr_valid/wr_src/wr_wa    : granted MDU/LSU write this cycle
//               qa/qb -> busy_a/busy_b   : decode source queries
//               sb_err                   : sticky double-issue error
// Revision    : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       iss_valid,
  input  logic       iss_src,
  input  logic [4:0] iss_rd,
  input  logic       wr_valid,
  input  logic       wr_src,
  input  logic [4:0] wr_wa,
  input  logic [4:0] qa,
  input  logic [4:0] qb,
  output logic       busy_a,
  output logic       busy_b,
  output logic       sb_err
);

  logic [31:0] pend_q, pend_d;
  logic [31:0] src_q,  src_d;
  logic        sb_err_q, sb_err_d;
  logic        wr_clr;

  always_comb begin
    // Only the unit that owns the entry may retire it; a stale write from
    // the other unit to the same register leaves the entry pending.
    wr_clr   = wr_valid && (src_q[wr_wa] == wr_src) && (wr_wa != REG_X0);
    pend_d   = pend_q;
    src_d    = src_q;
    sb_err_d = sb_err_q;
    if (wr_clr) begin
      pend_d[wr_wa] = 1'b0;
    end
    // Applied after the clear so a same-cycle set of the same register wins.
    if (iss_valid && (iss_rd != REG_X0)) begin
      pend_d[iss_rd] = 1'b1;
      src_d[iss_rd]  = iss_src;
      if (pend_q[iss_rd]) begin
        sb_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q   <= '0;
      src_q    <= '0;
      sb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      src_q    <= src_d;
      sb_err_q <= sb_err_d;
    end
  end

  // A retiring write this cycle is bypassed by the register file, so the
  // queried register is already usable.
  always_comb begin
    busy_a = pend_q[qa] && (qa != REG_X0) && !(wr_clr && (wr_wa == qa));
    busy_b = pend_q[qb] && (qb != REG_X0) && !(wr_clr && (wr_wa == qb));
  end

  assign sb_err = sb_err_q;

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_wb_arbiter
// Description : Shares the single register-file write port between the
//               pipeline writeback (highest priority), the MDU and the LSU,
//               with a starvation counter that asks the pipeline to bubble.
//               Contains the scoreboard instance for RAW hazard queries.
// Ports       : clock, reset (async active-low), bus (rf_wb_arbiter_if.slave)
// Parameters  : STARVE_LIMIT (1..15) - denied cycles before stall_req
// Config      : WB_ARB_RR_EN defined   -> MDU/LSU round-robin
//               WB_ARB_RR_EN undefined -> fixed priority, MDU over LSU
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic           clock,
  input  logic           reset,
  rf_wb_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

  gnt_e                gnt;
  logic [STARVE_W-1:0] cnt_q, cnt_d;
  logic                sec_valid;
  logic                sec_gnt;
  logic [4:0]          mux_wa;
  logic [31:0]         mux_wd;

`ifdef WB_ARB_RR_EN
  // 0: MDU has priority on the next contention, 1: LSU has priority.
  logic ptr_q, ptr_d;
`endif

  assign sec_valid = bus.mdu_valid || bus.lsu_valid;

  // Grant selection: pipeline first, then the secondaries. With the
  // pipeline idle a waiting secondary is always granted, which is what
  // makes stall_req effective.
  always_comb begin
    gnt = GNT_NONE;
    if (bus.pipe_wen) begin
      gnt = GNT_PIPE;
    end else if (bus.mdu_valid && bus.lsu_valid) begin
`ifdef WB_ARB_RR_EN
      gnt = ptr_q ? GNT_LSU : GNT_MDU;
`else
      gnt = GNT_MDU;
`endif
    end else if (bus.mdu_valid) begin
      gnt = GNT_MDU;
    end else if (bus.lsu_valid) begin
      gnt = GNT_LSU;
    end
  end

  assign sec_gnt = (gnt == GNT_MDU) || (gnt == GNT_LSU);

  always_comb begin
    mux_wa = '0;
    mux_wd = '0;
    case (gnt)
      GNT_PIPE: begin mux_wa = bus.pipe_wa; mux_wd = bus.pipe_wd; end
      GNT_MDU:  begin mux_wa = bus.mdu_wa;  mux_wd = bus.mdu_wd;  end
      GNT_LSU:  begin mux_wa = bus.lsu_wa;  mux_wd = bus.lsu_wd;  end
      default:  begin mux_wa = '0;          mux_wd = '0;          end
    endcase
  end

  // Outputs are forced low while reset is held, independent of requests.
  always_comb begin
    bus.mdu_ready = reset && (gnt == GNT_MDU);
    bus.lsu_ready = reset && (gnt == GNT_LSU);
    // Writes to x0 are consumed but never reach the register file.
    bus.rf_wen    = reset && (gnt != GNT_NONE) && (mux_wa != REG_X0);
    bus.rf_wa     = reset ? mux_wa : 5'd0;
    bus.rf_wd     = reset ? mux_wd : 32'd0;
  end

  // Starvation counter: saturates rather than wrapping so a long protocol
  // violation cannot silently drop stall_req.
  always_comb begin
    cnt_d = '0;
    if (sec_valid && !sec_gnt) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign bus.stall_req = (cnt_q >= LIMIT_C);

`ifdef WB_ARB_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (gnt == GNT_MDU) begin
      ptr_d = 1'b1;
    end else if (gnt == GNT_LSU) begin
      ptr_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  rf_scoreboard u_scoreboard (
    .clock     (clock),
    .reset     (reset),
    .iss_valid (bus.iss_valid),
    .iss_src   (bus.iss_src),
    .iss_rd    (bus.iss_rd),
    .wr_valid  (sec_gnt),
    .wr_src    ((gnt == GNT_LSU) ? SRC_LSU : SRC_MDU),
    .wr_wa     (mux_wa),
    .qa        (bus.qa),
    .qb        (bus.qb),
    .busy_a    (bus.busy_a),
    .busy_b    (bus.busy_b),
    .sb_err    (bus.sb_err)
  );

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter and pending-register scoreboard for the CPU register file. It shares the single register-file write port between three writers: the in-order pipeline writeback, the multiply/divide unit (MDU) and the load/store unit (LSU). It also tracks destination registers with outstanding long-latency results so that decode can stall on RAW hazards. It sits between the writeback stage, the MDU/LSU and the register-file write port (`wen`/`wa`/`wd`).

## Interface
- `STARVE_LIMIT`, 4: consecutive cycles a waiting MDU/LSU result may be denied before the pipeline is asked to bubble; legal range 1..15.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pipe_wen`, `pipe_wa[4:0]`, `pipe_wd[31:0]`  in  pipeline writeback request; no backpressure.
- `mdu_valid`, `mdu_wa[4:0]`, `mdu_wd[31:0]`  in  MDU result; `mdu_ready` out 1.
- `lsu_valid`, `lsu_wa[4:0]`, `lsu_wd[31:0]`  in  LSU result; `lsu_ready` out 1.
- `iss_valid` in 1, `iss_src` in 1 (0 = MDU, 1 = LSU), `iss_rd` in 5: a long-latency op is issued to `iss_rd`.
- `qa[4:0]`, `qb[4:0]`  in  decode source-register queries; `busy_a`, `busy_b` out 1.
- `stall_req`  out 1  pipeline must not assert `pipe_wen` next cycle.
- `rf_wen` out 1, `rf_wa` out 5, `rf_wd` out 32  drive the register-file write port.
- `sb_err`  out 1  sticky; set when an issue targets a register that is already pending.

## Operation
- Grant priority: the pipeline always wins. Otherwise the MDU and LSU compete, and the tie-break is set by the configuration macro.
- `mdu_ready`/`lsu_ready` are combinational grants. A transfer happens when `valid && ready`.
- Once `valid` is raised, it and the address/data must stay stable until the transfer; a bench assertion checks this.
- Output mux: `rf_*` carries the granted source. `rf_wen` is 0 when nothing is granted.
- A write to x0 is still granted and consumed, but `rf_wen` is driven 0 for it.
- Scoreboard: 32-bit `pend` plus a 32-bit `src` vector.
  - `iss_valid` with `iss_rd != 0` sets `pend[iss_rd]` and records `src`.
  - A granted MDU/LSU write clears `pend[wa]` only when `src[wa]` matches the writer.
- Same-cycle set and clear of the same register: the set wins.
- Issue to an already-pending register: `sb_err` is set and held until reset; the entry is overwritten.
- Query: `busy_x = pend[qx] && qx != 0`, except it reads 0 when the matching write is granted this cycle, because the register file bypasses `wd`.
- Starvation counter, 4 bits:
  - Increments each cycle a secondary source is valid but neither is granted.
  - Clears on any secondary grant or when no secondary is valid.
  - `stall_req = (cnt >= STARVE_LIMIT)`.
  - While `stall_req` is high and `pipe_wen` is low, a secondary is guaranteed a grant in that same cycle.
- `pipe_wen` asserted while `stall_req` is high is a protocol violation; the pipeline still wins, and a bench assertion flags it.

## Timing
- Reset values: `pend`=0, `src`=0, `cnt`=0, round-robin pointer=0 (MDU first), `sb_err`=0.
- Output values under reset: all outputs 0, `rf_*`=0.
- Grant latency: 0 cycles, combinational from `*_valid`, `pipe_wen` and registered state.
- Scoreboard, counter and pointer update on the rising edge after the event.
- Reset asserted mid-operation: all pending state is dropped immediately. Upstream units are flushed by the same reset.
- Path lengths: maximum combinational path is valid → grant → `rf_wd` mux; no path from `qa`/`qb` to any ready signal.

## Configuration
- `WB_ARB_RR_EN` defined: MDU and LSU arbitrate round-robin. After a secondary grant, the pointer moves to the other unit.
- `WB_ARB_RR_EN` undefined: fixed priority, MDU over LSU. No pointer register exists.
- The starvation counter still covers both secondaries in either build; with fixed priority, LSU can only starve behind the MDU, and `stall_req` does not cure that.

## Structure
- Shared `constants.vh`: `SRC_MDU`/`SRC_LSU` encodings, `REG_X0` and `STARVE_W` (4).
- The scoreboard is a natural sub-module, `rf_scoreboard`, containing the pend/src vectors, query logic and `sb_err`.
- Arbitration, the starvation counter and the output mux stay in the top module.

## Test plan
- `pipe_wen=1` (wa=5, wd=0x11) together with `mdu_valid` (wa=6): `rf_wa`=5, `mdu_ready`=0. Next cycle with `pipe_wen=0`: `rf_wa`=6, `rf_wd`=mdu data.
- Issue MDU to x7: `busy_a` for qa=7 is 1. In the cycle the MDU write to x7 is granted, `busy_a`=0 and `rf_wd` is the MDU data. The next cycle `pend[7]`=0.
- MDU and LSU both valid for 4 cycles with the pipeline idle:
  - `WB_ARB_RR_EN` defined: grants alternate MDU, LSU, MDU, LSU.
  - `WB_ARB_RR_EN` undefined: MDU is granted until it drops `valid`.
- `pipe_wen=1` continuously with `lsu_valid=1` and `STARVE_LIMIT`=4: `stall_req` rises in the 5th cycle. The pipeline drops `pipe_wen` and the LSU is granted; `stall_req` falls the next cycle.
- Issue to x3 twice without a writeback: `sb_err`=1 and stays 1. Issue to x0: `pend` is unchanged and `busy` for x0 is always 0.
- Assert `reset` low while x9 is pending and the counter is 3: all outputs go to 0 immediately; after release, `busy` for x9 is 0 and `stall_req`=0.
